// File: rtl/word_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on a valid/ready handshake and emits one bit per clock.
// Define SERIALIZER_LSB_FIRST_EN to send each word LSB first (default is MSB first).
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);
    // Handshake: a word transfers on a rising edge where din_valid & din_ready;
    // din_ready is high only in IDLE outside reset, and din is ignored otherwise.

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       gap_cnt;
    logic             accept;

    assign din_ready = (state == S_IDLE) & ~rst;
    assign accept    = din_valid & din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bit_valid  = 1'b0;
        bit_out    = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bit_valid = 1'b1;
`ifdef SERIALIZER_LSB_FIRST_EN
                bit_out   = shift_reg[0];
`else
                bit_out   = shift_reg[WIDTH-1];
`endif
                if (bit_cnt == BIT_LAST) begin
                    frame_done = 1'b1;
                    state_next = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                // Unused encoding: report idle and fall back to IDLE on the next edge.
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: counters saturate at their terminal values instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shift_reg <= din;
                        bit_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
`ifdef SERIALIZER_LSB_FIRST_EN
                    shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
`else
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
`endif
                    if (bit_cnt != BIT_LAST) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    gap_cnt <= '0;
                end
                S_GAP: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: three instances (8-bit no gap, 8-bit gap 3, 4-bit no gap).
// Each cycle's outputs are checked against an expected queue filled from hand-written word tables.
`timescale 1ns/1ps
module tb_word_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] d_din = '0;
    logic       d_valid = 1'b0;
    logic       d_ready, d_bit, d_bv, d_fd, d_busy;

    logic [7:0] g_din = '0;
    logic       g_valid = 1'b0;
    logic       g_ready, g_bit, g_bv, g_fd, g_busy;

    logic [3:0] n_din = '0;
    logic       n_valid = 1'b0;
    logic       n_ready, n_bit, n_bv, n_fd, n_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle observation {din_ready, busy, bit_valid, bit_out, frame_done}.
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(8), .GAP(0)) u_d (
        .clk(clk), .rst(rst), .din(d_din), .din_valid(d_valid), .din_ready(d_ready),
        .bit_out(d_bit), .bit_valid(d_bv), .frame_done(d_fd), .busy(d_busy)
    );

    word_serializer #(.WIDTH(8), .GAP(3)) u_g (
        .clk(clk), .rst(rst), .din(g_din), .din_valid(g_valid), .din_ready(g_ready),
        .bit_out(g_bit), .bit_valid(g_bv), .frame_done(g_fd), .busy(g_busy)
    );

    word_serializer #(.WIDTH(4), .GAP(0)) u_n (
        .clk(clk), .rst(rst), .din(n_din), .din_valid(n_valid), .din_ready(n_ready),
        .bit_out(n_bit), .bit_valid(n_bv), .frame_done(n_fd), .busy(n_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(5'b10000);
    endtask

    task automatic exp_gap(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(5'b01000);
    endtask

    // Bits listed in transmission order: seq[w-1] goes out first.
    task automatic exp_bits(input logic [31:0] seq, input int w);
        for (int i = 0; i < w; i++) begin
            exp_q.push_back({2'b01, 1'b1, seq[w-1-i], (i == w - 1)});
        end
    endtask

    // Word as loaded; order follows the build's bit-order option.
    task automatic exp_word(input logic [31:0] word, input int w);
        logic [31:0] seq;
        seq = '0;
        for (int i = 0; i < w; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            seq[w-1-i] = word[i];
`else
            seq[i] = word[i];
`endif
        end
        exp_bits(seq, w);
    endtask

    task automatic run_stream(input int sel, input string name, input int n);
        logic [4:0] obs;
        logic [4:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (sel)
                0:       obs = {d_ready, d_busy, d_bv, d_bit, d_fd};
                1:       obs = {g_ready, g_busy, g_bv, g_bit, g_fd};
                default: obs = {n_ready, n_busy, n_bv, n_bit, n_fd};
            endcase
            if (exp_q.size() == 0) begin
                check($sformatf("%s_underflow_c%0d", name, i + 1), 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_c%0d", name, i + 1), 32'(obs), 32'(e));
            end
        end
    endtask

    initial begin
        logic [7:0] seq8;

        // Reset with an offered word: reset wins, nothing is accepted.
        d_din   = 8'hFF;
        d_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(d_ready), 32'd0);
        check("rst_busy", 32'(d_busy), 32'd0);
        check("rst_bv", 32'(d_bv), 32'd0);
        check("rst_bit", 32'(d_bit), 32'd0);
        check("rst_fd", 32'(d_fd), 32'd0);
        d_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check("post_rst_ready", 32'(d_ready), 32'd1);
        check("post_rst_busy", 32'(d_busy), 32'd0);

        // Single word 8'h1E, accepted on edge 0.
        @(negedge clk);
        d_din   = 8'h1E;
        d_valid = 1'b1;
        @(posedge clk);
        #1 d_valid = 1'b0;
`ifdef SERIALIZER_LSB_FIRST_EN
        seq8 = 8'b01111000;
`else
        seq8 = 8'b00011110;
`endif
        exp_bits(32'(seq8), 8);
        exp_idle(2);
        run_stream(0, "single", 10);

        // Stall: next word offered during SHIFT is taken on the first IDLE cycle.
        d_din   = 8'hA5;
        d_valid = 1'b1;
        @(posedge clk);
        #1 d_din = 8'h3C;
        exp_word(32'h A5, 8);
        exp_idle(1);
        exp_word(32'h3C, 8);
        run_stream(0, "stall", 17);
        d_valid = 1'b0;
        exp_idle(2);
        run_stream(0, "stall_tail", 2);

        // Gap of 3 with din_valid held high: next word 12 cycles after the previous.
        g_din   = 8'hC3;
        g_valid = 1'b1;
        @(posedge clk);
        #1 g_din = 8'h81;
        exp_word(32'hC3, 8);
        exp_gap(3);
        exp_idle(1);
        exp_word(32'h81, 8);
        run_stream(1, "gap", 20);
        g_valid = 1'b0;
        exp_gap(3);
        exp_idle(2);
        run_stream(1, "gap_tail", 5);

        // 4-bit words back to back, with the single idle 0 bit between them.
        n_din   = 4'b1010;
        n_valid = 1'b1;
        @(posedge clk);
        #1 n_din = 4'b0101;
        exp_word(32'b1010, 4);
        exp_idle(1);
        exp_word(32'b0101, 4);
        run_stream(2, "w4", 9);
        n_valid = 1'b0;
        exp_idle(2);
        run_stream(2, "w4_tail", 2);

        // Reset mid-word: outputs clear at once, then no stale bits after release.
        d_din   = 8'hF0;
        d_valid = 1'b1;
        @(posedge clk);
        #1 d_valid = 1'b0;
        exp_bits(32'b111, 3);
        exp_q.delete();
        exp_q.push_back(5'b01110);
        exp_q.push_back(5'b01110);
        exp_q.push_back(5'b01110);
        run_stream(0, "mid", 3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bv", 32'(d_bv), 32'd0);
        check("mid_rst_bit", 32'(d_bit), 32'd0);
        check("mid_rst_busy", 32'(d_busy), 32'd0);
        check("mid_rst_ready", 32'(d_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(d_ready), 32'd1);
        exp_idle(8);
        run_stream(0, "mid_after", 8);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial stage that accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock. It sits directly upstream of the serial sequence-detector FSMs: `bit_out` drives the detector's serial input `a`, and both blocks share `clk` and `rst`. An optional idle gap between words lets benches and detectors see defined word boundaries.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `GAP`, 0: idle cycles inserted after each word, with `bit_valid` low and `bit_out` at 0; legal range 0..255.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `din`  input  WIDTH  parallel word; sampled only on a handshake.
- `din_valid`  input  1  upstream offers `din`.
- `din_ready`  output  1  block can accept a word this cycle.
- `bit_out`  output  1  current serial bit; 0 whenever `bit_valid` is low.
- `bit_valid`  output  1  `bit_out` carries a data bit this cycle.
- `frame_done`  output  1  one-cycle pulse, high during the last bit of a word.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, SHIFT and GAP.
- **Reset.** While `rst` is high:
  - state is IDLE;
  - `shift_reg`, the bit counter and the gap counter are all 0;
  - `bit_out`, `bit_valid`, `frame_done` and `busy` are 0;
  - `din_ready` is forced to 0.
- **Handshake.** A transfer happens on a rising edge where `din_valid & din_ready` is 1.
  - `din_ready` = (state == IDLE) & ~rst.
  - `din` and `din_valid` are ignored when `din_ready` is low.
  - Upstream may hold `din_valid` high indefinitely.
- **IDLE.**
  - On a transfer: `shift_reg` <= `din`, bit counter <= 0, next state SHIFT.
  - Otherwise the FSM stays in IDLE.
- **SHIFT.**
  - Outputs: `bit_valid` = 1; `bit_out` = `shift_reg[WIDTH-1]` (MSB first).
  - Each edge shifts `shift_reg` left by one and increments the counter.
  - When the counter reaches WIDTH-1, `frame_done` = 1 for that cycle.
  - The next state after the last bit is GAP if GAP > 0, otherwise IDLE.
- **GAP.**
  - Outputs: `bit_valid` = 0, `bit_out` = 0.
  - The gap counter runs from 0 to GAP-1, then the FSM returns to IDLE.
- **Registers and widths.**
  - All outputs except `din_ready` come from registered state and `shift_reg` only; there is no combinational path from `din` or `din_valid` to any output.
  - The bit counter is $clog2(WIDTH) bits wide.
  - The gap counter is 8 bits wide.
  - Counters never wrap beyond their terminal value.
- **Unreachable state encodings** recover to IDLE on the next edge.
- **Reset mid-word.** The word is discarded. Outputs clear immediately (asynchronously), and the FSM resumes in IDLE after `rst` deasserts. There is no partial-word resume.

## Timing
- **Accept to first bit.** Accept on edge k; the first bit is valid in the cycle following edge k.
- **Last bit.** The last bit is valid in cycle k+WIDTH-1 (counting the first bit as cycle k); `frame_done` is high in the same cycle.
- **`din_ready` return.** `din_ready` rises GAP+1 cycles after the last-bit cycle ends, i.e. in the first IDLE cycle.
- **Throughput.** One word per WIDTH+GAP+1 cycles when `din_valid` is held high.
- **Protocol.** With GAP=0, a single IDLE cycle separates consecutive words; the downstream detector sees one 0 bit there, which is part of the defined protocol.
- **Simultaneous events.** `rst` rising in the same cycle as a handshake: reset wins and no word is accepted.

## Configuration
- **`SERIALIZER_LSB_FIRST_EN` defined:**
  - `bit_out` = `shift_reg[0]`;
  - `shift_reg` shifts right;
  - the word goes out LSB first.
- **Undefined (default):** MSB first, as described under Operation.
- **Unaffected by the macro:** handshake, latency, `frame_done` and the gap behaviour are identical in both builds.

## Test plan
- **Reset.** Assert `rst` mid-SHIFT. Outputs go to 0 immediately. After release, `din_ready` = 1 on the first cycle and no stale bits appear.
- **Single word, MSB first.** WIDTH=8, GAP=0, `din`=8'h1E accepted on edge 0.
  - `bit_out` sequence is 0,0,0,1,1,1,1,0 on cycles 1..8 with `bit_valid` high.
  - `frame_done` is high only in cycle 8.
  - `din_ready` is 1 in cycle 9.
- **LSB first.** Same stimulus with `SERIALIZER_LSB_FIRST_EN` defined. `bit_out` is 0,1,1,1,1,0,0,0.
- **Gap.** GAP=3 with `din_valid` held high. Each 8-bit burst is followed by 3 cycles of `bit_valid`=0 and `bit_out`=0, then one IDLE cycle; the next word starts 12 cycles after the previous one.
- **Handshake stall.** `din_valid` pulses while `busy` is high. No transfer occurs, the in-flight word is unchanged, and the held `din` is accepted on the first IDLE cycle.
- **End-to-end.** Connect to the sequence detector, WIDTH=4, words 4'b1010 and 4'b0101. The detector output matches a bit-level reference model over the complete `bit_out` stream, including idle bits.
